// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch -- fetch stage of the rv32i single-cycle core.
//
// Owns the program counter, fetches one instruction word at a time from
// instruction memory over a req/ack handshake, and presents a registered
// instruction together with its PC to the instruction controller. When the
// controller retires the instruction, the PC advances to pc+4 or to the
// resolved redirect target. A redirect to a non-word-aligned target parks the
// stage in a fault state that only reset can leave.
//
// Build option:
//   FETCH_PREFETCH_EN  when defined, adds a one-entry prefetch buffer that
//                      fetches pc+4 while the current instruction is held,
//                      so zero-wait memory sustains one instruction per
//                      cycle. When undefined, memory is idle while an
//                      instruction is held (one instruction per two cycles).
//
// Parameters:
//   RESET_PC         first PC fetched after reset (must be word-aligned)
//
// Ports:
//   clk              core clock, rising edge
//   rst_n            asynchronous active-low reset
//   imem_req         fetch request, held until acked
//   imem_addr        word address of the request, stable while imem_req=1
//   imem_ack         memory accepts the request and returns data this cycle
//   imem_rdata       instruction word, valid with imem_ack
//   instr            instruction presented to the controller
//   instr_valid      instr / pc / pc_plus4 are valid
//   pc               address of instr
//   pc_plus4         pc + 4 (link value for jump-and-link)
//   instr_ready      controller retires instr this cycle
//   redirect         retiring instruction redirects the PC
//   redirect_target  new PC when redirect=1
//   misalign_err     sticky: a redirect target was not word-aligned
// ---------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        misalign_err
);

  // addi x0, x0, 0 -- harmless value shown on instr before the first fetch.
  localparam logic [31:0] NOP = 32'h0000_0013;

  // S_REQ   : fetching the word at pc, nothing presented
  // S_HOLD  : instruction presented, waiting for retire
  // S_FAULT : misaligned redirect seen, stage halted until reset
  // S_DRAIN : (prefetch build only) a stale prefetch is still outstanding
  //           after a redirect; wait for its ack, drop the data, then fetch
  //           the redirect target
  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_HOLD  = 2'd1,
    S_FAULT = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic [31:0] instr_q, instr_d;
  logic        instr_valid_q, instr_valid_d;
  logic        imem_req_q, imem_req_d;
  logic [31:0] imem_addr_q, imem_addr_d;
  logic        misalign_err_q, misalign_err_d;

`ifdef FETCH_PREFETCH_EN
  // Prefetch buffer: holds the word at pc+4 once it has been acked.
  logic        pf_valid_q, pf_valid_d;
  logic [31:0] pf_data_q, pf_data_d;
`endif

  logic        ack_fire;
  logic        retire;
  logic        bad_target;
  logic [31:0] next_pc;

  // An ack only counts against a request we are actually driving; this also
  // discards a late ack from a transaction abandoned by reset, because
  // imem_req is low for the first cycle after reset release.
  assign ack_fire   = imem_req_q & imem_ack;
  assign retire     = instr_valid_q & instr_ready;
  assign bad_target = redirect & (redirect_target[1:0] != 2'b00);
  // pc_plus4_q always equals pc_q + 4 (32-bit wrap), so reuse it here.
  assign next_pc    = redirect ? redirect_target : pc_plus4_q;

  // -------------------------------------------------------------------------
  // State register (all flops live here)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_REQ;
      pc_q           <= RESET_PC;
      pc_plus4_q     <= RESET_PC + 32'd4;
      instr_q        <= NOP;
      instr_valid_q  <= 1'b0;
      imem_req_q     <= 1'b0;
      imem_addr_q    <= RESET_PC;
      misalign_err_q <= 1'b0;
`ifdef FETCH_PREFETCH_EN
      pf_valid_q     <= 1'b0;
      pf_data_q      <= NOP;
`endif
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      pc_plus4_q     <= pc_plus4_d;
      instr_q        <= instr_d;
      instr_valid_q  <= instr_valid_d;
      imem_req_q     <= imem_req_d;
      imem_addr_q    <= imem_addr_d;
      misalign_err_q <= misalign_err_d;
`ifdef FETCH_PREFETCH_EN
      pf_valid_q     <= pf_valid_d;
      pf_data_q      <= pf_data_d;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic: state, PC, presented instruction, prefetch buffer
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
`ifdef FETCH_PREFETCH_EN
    pf_valid_d = pf_valid_q;
    pf_data_d  = pf_data_q;
`endif

    case (state_q)
      S_REQ: begin
        if (ack_fire) begin
          state_d = S_HOLD;
          instr_d = imem_rdata;
        end
      end

      S_HOLD: begin
`ifdef FETCH_PREFETCH_EN
        if (retire) begin
          pc_d       = next_pc;
          pf_valid_d = 1'b0;
          if (bad_target) begin
            state_d = S_FAULT;
          end else if (redirect) begin
            // Whatever was prefetched belongs to the wrong path. If the
            // prefetch is still outstanding we must finish the handshake
            // before the address may change.
            if (imem_req_q && !imem_ack) begin
              state_d = S_DRAIN;
            end else begin
              state_d = S_REQ;
            end
          end else if (pf_valid_q) begin
            instr_d = pf_data_q;
          end else if (ack_fire) begin
            // Prefetch lands in the retire cycle: forward it straight to instr.
            instr_d = imem_rdata;
          end else begin
            // Prefetch still outstanding: its address is already the new pc,
            // so the request simply continues in S_REQ.
            state_d = S_REQ;
          end
        end else if (ack_fire) begin
          pf_valid_d = 1'b1;
          pf_data_d  = imem_rdata;
        end
`else
        if (retire) begin
          pc_d    = next_pc;
          state_d = bad_target ? S_FAULT : S_REQ;
        end
`endif
      end

`ifdef FETCH_PREFETCH_EN
      S_DRAIN: begin
        if (ack_fire) begin
          state_d = S_REQ;
        end
      end
`endif

      default: begin
        // S_FAULT is terminal until reset.
        state_d = state_q;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic: every output is a flop, so compute its next value from the
  // next state.
  // -------------------------------------------------------------------------
  always_comb begin
    instr_valid_d  = (state_d == S_HOLD);
    misalign_err_d = (state_d == S_FAULT);
    pc_plus4_d     = pc_d + 32'd4;
`ifdef FETCH_PREFETCH_EN
    case (state_d)
      S_REQ: begin
        imem_req_d  = 1'b1;
        imem_addr_d = pc_d;
      end
      S_HOLD: begin
        // Keep fetching pc+4 until the buffer holds it.
        imem_req_d  = !pf_valid_d;
        imem_addr_d = pc_plus4_d;
      end
      S_DRAIN: begin
        imem_req_d  = 1'b1;
        imem_addr_d = imem_addr_q;
      end
      default: begin
        imem_req_d  = 1'b0;
        imem_addr_d = imem_addr_q;
      end
    endcase
`else
    imem_req_d  = (state_d == S_REQ);
    imem_addr_d = pc_d;
`endif
  end

  assign imem_req     = imem_req_q;
  assign imem_addr    = imem_addr_q;
  assign instr        = instr_q;
  assign instr_valid  = instr_valid_q;
  assign pc           = pc_q;
  assign pc_plus4     = pc_plus4_q;
  assign misalign_err = misalign_err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// Self-checking bench for instr_fetch. A behavioural instruction memory
// answers every request with addr+1 after a programmable number of wait
// cycles. Each scenario pushes the (pc, instr) pairs it expects into a
// scoreboard queue and pops them as the fetch stage presents instructions.
// Outputs are sampled 1 time unit after the falling clock edge.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef FETCH_PREFETCH_EN
  localparam int CPI = 1;
`else
  localparam int CPI = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        misalign_err;

  instr_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .instr           (instr),
    .instr_valid     (instr_valid),
    .pc              (pc),
    .pc_plus4        (pc_plus4),
    .instr_ready     (instr_ready),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .misalign_err    (misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Memory model controls
  int   mem_lat     = 0;
  bit   mem_en      = 1'b0;
  bit   stale_pulse = 1'b0;
  int   wait_cnt    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Instruction memory: data = address + 1, ack after mem_lat wait cycles.
  // stale_pulse forces a spurious ack carrying garbage data.
  always @(negedge clk) begin
    if (stale_pulse) begin
      imem_ack   <= 1'b1;
      imem_rdata <= 32'hDEAD_BEEF;
      wait_cnt   <= 0;
    end else if (mem_en && imem_req === 1'b1 && wait_cnt >= mem_lat) begin
      imem_ack   <= 1'b1;
      imem_rdata <= imem_addr + 32'd1;
      wait_cnt   <= 0;
    end else if (mem_en && imem_req === 1'b1) begin
      imem_ack   <= 1'b0;
      wait_cnt   <= wait_cnt + 1;
    end else begin
      imem_ack   <= 1'b0;
      wait_cnt   <= 0;
    end
  end

  // Advance to the sampling point of the next cycle.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Reset for two cycles and release just after a falling edge.
  task automatic apply_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    exp_t e;
    mem_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_imem_req: got %0h want 0", imem_req); end
    n_checks++; if (imem_addr !== RESET_PC) begin n_fail++; $display("FAIL reset_imem_addr: got %08h want %08h", imem_addr, RESET_PC); end
    n_checks++; if (instr !== NOP) begin n_fail++; $display("FAIL reset_instr: got %08h want %08h", instr, NOP); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_instr_valid: got %0h want 0", instr_valid); end
    n_checks++; if (pc !== RESET_PC) begin n_fail++; $display("FAIL reset_pc: got %08h want %08h", pc, RESET_PC); end
    e.pc = RESET_PC + 32'd4;
    n_checks++; if (pc_plus4 !== e.pc) begin n_fail++; $display("FAIL reset_pc_plus4: got %08h want %08h", pc_plus4, e.pc); end
    n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL reset_misalign_err: got %0h want 0", misalign_err); end
    step();
    step();
    rst_n = 1'b1;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_release_req_early: got %0h want 0", imem_req); end
    step();
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL reset_first_req: got %0h want 1", imem_req); end
    n_checks++; if (imem_addr !== RESET_PC) begin n_fail++; $display("FAIL reset_first_addr: got %08h want %08h", imem_addr, RESET_PC); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_sequential();
    exp_t e;
    int   last_cyc;
    logic [31:0] a;
    mem_lat     = 0;
    mem_en      = 1'b1;
    redirect    = 1'b0;
    instr_ready = 1'b0;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      a = RESET_PC + 32'(4 * i);
      e.pc = a;
      e.instr = a + 32'd1;
      sb_q.push_back(e);
    end
    instr_ready = 1'b1;
    last_cyc = -1;
    for (int c = 0; c < 60 && sb_q.size() > 0; c++) begin
      step();
      if (instr_valid === 1'b1) begin
        e = sb_q.pop_front();
        $display("seq txn: pc=%08h instr=%08h cycle=%0d", pc, instr, cyc);
        n_checks++; if (pc !== e.pc) begin n_fail++; $display("FAIL seq_pc: got %08h want %08h", pc, e.pc); end
        n_checks++; if (instr !== e.instr) begin n_fail++; $display("FAIL seq_instr: got %08h want %08h", instr, e.instr); end
        a = e.pc + 32'd4;
        n_checks++; if (pc_plus4 !== a) begin n_fail++; $display("FAIL seq_pc_plus4: got %08h want %08h", pc_plus4, a); end
        if (last_cyc >= 0) begin
          n_checks++; if (cyc - last_cyc != CPI) begin n_fail++; $display("FAIL seq_cpi: got %0d want %0d", cyc - last_cyc, CPI); end
        end
        last_cyc = cyc;
      end
    end
    instr_ready = 1'b0;
    n_checks++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL seq_timeout: %0d instructions never presented, want 0", sb_q.size()); end
    sb_q.delete();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_wait_states();
    exp_t e;
    mem_lat     = 3;
    mem_en      = 1'b1;
    instr_ready = 1'b0;
    apply_reset();
    e.pc = RESET_PC;
    e.instr = RESET_PC + 32'd1;
    sb_q.push_back(e);
    for (int k = 0; k < 4; k++) begin
      step();
      n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL wait_req_held[%0d]: got %0h want 1", k, imem_req); end
      n_checks++; if (imem_addr !== RESET_PC) begin n_fail++; $display("FAIL wait_addr_held[%0d]: got %08h want %08h", k, imem_addr, RESET_PC); end
      n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL wait_valid_low[%0d]: got %0h want 0", k, instr_valid); end
    end
    step();
    n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL wait_valid_after_ack: got %0h want 1", instr_valid); end
    if (instr_valid === 1'b1) begin
      e = sb_q.pop_front();
      $display("wait txn: pc=%08h instr=%08h", pc, instr);
      n_checks++; if (instr !== e.instr) begin n_fail++; $display("FAIL wait_instr: got %08h want %08h", instr, e.instr); end
      n_checks++; if (pc !== e.pc) begin n_fail++; $display("FAIL wait_pc: got %08h want %08h", pc, e.pc); end
    end
    sb_q.delete();
  endtask

  // -------------------------------------------------------------------------
  // Starts in HOLD with instr_ready low.
  task automatic test_redirect();
    exp_t e;
    mem_lat = 0;
    step();
    step();
    step();
    e.pc = 32'h0000_0100;
    e.instr = 32'h0000_0101;
    sb_q.push_back(e);
    redirect_target = 32'h0000_0100;
    redirect        = 1'b1;
    instr_ready     = 1'b1;
    step();
    instr_ready     = 1'b0;
    redirect        = 1'b0;
    redirect_target = 32'h0;
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL redir_req: got %0h want 1", imem_req); end
    n_checks++; if (imem_addr !== 32'h0000_0100) begin n_fail++; $display("FAIL redir_addr: got %08h want 00000100", imem_addr); end
    n_checks++; if (pc !== 32'h0000_0100) begin n_fail++; $display("FAIL redir_pc: got %08h want 00000100", pc); end
    n_checks++; if (pc_plus4 !== 32'h0000_0104) begin n_fail++; $display("FAIL redir_pc_plus4: got %08h want 00000104", pc_plus4); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL redir_valid_low: got %0h want 0", instr_valid); end
    step();
    n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL redir_valid: got %0h want 1", instr_valid); end
    if (instr_valid === 1'b1) begin
      e = sb_q.pop_front();
      $display("redir txn: pc=%08h instr=%08h", pc, instr);
      n_checks++; if (instr !== e.instr) begin n_fail++; $display("FAIL redir_instr: got %08h want %08h", instr, e.instr); end
      n_checks++; if (pc !== e.pc) begin n_fail++; $display("FAIL redir_txn_pc: got %08h want %08h", pc, e.pc); end
    end
    sb_q.delete();
  endtask

  // -------------------------------------------------------------------------
  // Starts in HOLD with instr_ready low.
  task automatic test_wrap();
    exp_t e;
    logic [31:0] want_addr;
    e.pc = 32'hFFFF_FFFC; e.instr = 32'hFFFF_FFFD; sb_q.push_back(e);
    e.pc = 32'h0000_0000; e.instr = 32'h0000_0001; sb_q.push_back(e);
    redirect_target = 32'hFFFF_FFFC;
    redirect        = 1'b1;
    instr_ready     = 1'b1;
    step();
    instr_ready     = 1'b0;
    redirect        = 1'b0;
    for (int c = 0; c < 6 && instr_valid !== 1'b1; c++) step();
    e = sb_q.pop_front();
    $display("wrap txn: pc=%08h instr=%08h pc_plus4=%08h", pc, instr, pc_plus4);
    n_checks++; if (pc !== e.pc) begin n_fail++; $display("FAIL wrap_top_pc: got %08h want %08h", pc, e.pc); end
    n_checks++; if (instr !== e.instr) begin n_fail++; $display("FAIL wrap_top_instr: got %08h want %08h", instr, e.instr); end
    n_checks++; if (pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pc_plus4: got %08h want 00000000", pc_plus4); end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    want_addr = (CPI == 1) ? 32'h0000_0004 : 32'h0000_0000;
    n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL wrap_next_pc: got %08h want 00000000", pc); end
    n_checks++; if (pc_plus4 !== 32'h4) begin n_fail++; $display("FAIL wrap_next_pc_plus4: got %08h want 00000004", pc_plus4); end
    n_checks++; if (imem_addr !== want_addr) begin n_fail++; $display("FAIL wrap_next_addr: got %08h want %08h", imem_addr, want_addr); end
    for (int c = 0; c < 6 && instr_valid !== 1'b1; c++) step();
    e = sb_q.pop_front();
    $display("wrap txn: pc=%08h instr=%08h", pc, instr);
    n_checks++; if (instr !== e.instr) begin n_fail++; $display("FAIL wrap_zero_instr: got %08h want %08h", instr, e.instr); end
    n_checks++; if (pc !== e.pc) begin n_fail++; $display("FAIL wrap_zero_pc: got %08h want %08h", pc, e.pc); end
    sb_q.delete();
  endtask

  // -------------------------------------------------------------------------
  // Starts in HOLD with instr_ready low.
  task automatic test_misalign();
    redirect_target = 32'h0000_0102;
    redirect        = 1'b1;
    instr_ready     = 1'b1;
    step();
    instr_ready     = 1'b0;
    redirect        = 1'b0;
    n_checks++; if (misalign_err !== 1'b1) begin n_fail++; $display("FAIL misalign_err_set: got %0h want 1", misalign_err); end
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL misalign_req_low: got %0h want 0", imem_req); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL misalign_valid_low: got %0h want 0", instr_valid); end
    for (int k = 0; k < 8; k++) begin
      instr_ready     = 1'($urandom_range(0, 1));
      redirect        = 1'($urandom_range(0, 1));
      redirect_target = 32'h0000_0200;
      step();
      n_checks++; if (imem_req !== 1'b0 || misalign_err !== 1'b1) begin n_fail++; $display("FAIL misalign_sticky[%0d]: got req=%0h err=%0h want req=0 err=1", k, imem_req, misalign_err); end
    end
    instr_ready = 1'b0;
    redirect    = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL misalign_cleared_by_reset: got %0h want 0", misalign_err); end
    step();
    rst_n = 1'b1;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_stale_ack();
    exp_t e;
    mem_lat     = 5;
    mem_en      = 1'b1;
    instr_ready = 1'b0;
    apply_reset();
    step();
    step();
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL stale_pending_req: got %0h want 1", imem_req); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stale_reset_req: got %0h want 0", imem_req); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL stale_reset_valid: got %0h want 0", instr_valid); end
    n_checks++; if (pc !== RESET_PC) begin n_fail++; $display("FAIL stale_reset_pc: got %08h want %08h", pc, RESET_PC); end
    mem_en      = 1'b0;
    stale_pulse = 1'b1;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    stale_pulse = 1'b0;
    mem_lat     = 0;
    mem_en      = 1'b1;
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL stale_ack_ignored_valid: got %0h want 0", instr_valid); end
    n_checks++; if (instr !== NOP) begin n_fail++; $display("FAIL stale_ack_ignored_instr: got %08h want %08h", instr, NOP); end
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin n_fail++; $display("FAIL stale_new_req: got req=%0h addr=%08h want req=1 addr=%08h", imem_req, imem_addr, RESET_PC); end
    e.pc = RESET_PC;
    e.instr = RESET_PC + 32'd1;
    sb_q.push_back(e);
    for (int c = 0; c < 6 && instr_valid !== 1'b1; c++) step();
    n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL stale_first_valid: got %0h want 1", instr_valid); end
    e = sb_q.pop_front();
    $display("stale txn: pc=%08h instr=%08h", pc, instr);
    n_checks++; if (instr !== e.instr) begin n_fail++; $display("FAIL stale_first_instr: got %08h want %08h", instr, e.instr); end
    n_checks++; if (pc !== e.pc) begin n_fail++; $display("FAIL stale_first_pc: got %08h want %08h", pc, e.pc); end
    sb_q.delete();
  endtask

  // -------------------------------------------------------------------------
  initial begin
    #1;
    test_reset();
    test_sequential();
    test_wait_states();
    test_redirect();
    test_wrap();
    test_misalign();
    test_stale_ack();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t want completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Fetch stage of the rv32i single-cycle core, sitting directly upstream of the instruction controller. Owns the program counter, issues word requests to instruction memory with a req/ack handshake, and presents one registered 32-bit instruction with its PC to the controller. Accepts the resolved next-PC redirect from the branch/jump logic when the current instruction retires, and stalls the core while memory is slow.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset; must be word-aligned
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request; held until acked
- imem_addr  out  32  word address of request; stable while imem_req=1
- imem_ack  in  1  memory accepts request and returns data this cycle; may be high in the same cycle as imem_req
- imem_rdata  in  32  instruction word, valid when imem_ack=1
- instr  out  32  instruction to controller
- instr_valid  out  1  instr/pc are valid
- pc  out  32  address of instr
- pc_plus4  out  32  pc+4, for the link write of jump-and-link
- instr_ready  in  1  core retires instr this cycle; ignored unless instr_valid=1
- redirect  in  1  retiring instruction redirects the PC; sampled only on retire
- redirect_target  in  32  new PC when redirect=1
- misalign_err  out  1  sticky: redirect target not word-aligned

## Operation
- Retire = instr_valid & instr_ready. Next PC = redirect ? redirect_target : pc+4, 32-bit wrap (32'hFFFF_FFFC+4 = 0).
- States:
  - REQ: imem_req=1, imem_addr=PC. On imem_ack, latch imem_rdata into instr and go to HOLD.
  - HOLD: instr_valid=1. On retire, update PC and go to REQ, or to FAULT if redirect=1 and redirect_target[1:0]≠0.
  - FAULT: imem_req=0, instr_valid=0, misalign_err=1. Exit only by reset.
- imem_ack while imem_req=0 is ignored.
- In HOLD, instr, pc and pc_plus4 stay constant until retire.
- redirect while not retiring is ignored.
- Reset mid-transaction abandons the request; a late ack arriving after reset release but before the new request is ignored.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, instr=32'h0000_0013 (NOP), instr_valid=0, pc=RESET_PC, pc_plus4=RESET_PC+4, misalign_err=0; state=REQ.
- imem_req rises at the first rising edge after rst_n deasserts. All outputs are registered.
- Ack in cycle N: instr_valid=1 from cycle N+1.
- Retire in cycle M: new pc and imem_req=1 in cycle M+1, instr_valid=0 in M+1.
- With zero-wait memory, steady-state throughput is 1 instruction per 2 cycles.

## Configuration
- FETCH_PREFETCH_EN defined: adds a one-entry prefetch buffer.
  - While in HOLD, issue a request for pc+4 and store the acked word in the buffer.
  - On retire without redirect with the buffer full, the buffer loads into instr at M+1 and instr_valid stays 1. With zero-wait memory this gives 1 instruction per cycle.
  - On retire with redirect, the buffer is flushed. A request still in flight is held until acked and its data discarded, then the target is requested.
  - If retire coincides with ack of the prefetch and there is no redirect, the acked data goes directly to instr.
- Not defined: no buffer; imem_req=0 in HOLD; behaviour exactly as in Operation.

## Test plan
- Zero-wait memory returning imem_rdata = addr+1 from reset, RESET_PC=0, instr_ready=1 -> pc sequence 0,4,8,… with instr 1,5,9,…; 2 cycles per instruction (1 with FETCH_PREFETCH_EN).
- Ack delayed 3 cycles -> imem_req and imem_addr held stable for 4 cycles; instr_valid rises the cycle after ack.
- Retire with redirect=1, target 32'h0000_0100 -> next imem_addr=0x100, pc=0x100, pc_plus4=0x104. With prefetch, the in-flight pc+4 data is never presented.
- Retire with redirect=1, target 32'h0000_0102 -> misalign_err=1 and imem_req=0 permanently; cleared only by rst_n low.
- rst_n asserted while imem_req=1 with ack pending, released, then stale ack pulsed -> outputs at reset values; first presented instr is from RESET_PC.
- pc=32'hFFFF_FFFC retires without redirect -> next pc=0, pc_plus4 at 0xFFFF_FFFC reads 0.
